// File: rtl/tl_async_source_arb_if.sv
// Bundle of requester-side and enqueue-side handshake signals for tl_async_source_arb.
// The arbiter uses the slave modport; whatever drives requesters and the crossing uses master.
interface tl_async_source_arb_if #(
  parameter int N   = 4,
  parameter int W   = 64,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_bits;
  logic [N-1:0]   req_last;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_bits;
  logic           out_last;
  logic [IDW-1:0] out_id;
  logic           busy;

  modport master (
    output req_valid, req_bits, req_last, out_ready,
    input  req_ready, out_valid, out_bits, out_last, out_id, busy
  );

  modport slave (
    input  req_valid, req_bits, req_last, out_ready,
    output req_ready, out_valid, out_bits, out_last, out_id, busy
  );
endinterface

// File: rtl/tl_async_source_arb.sv
// Round-robin, message-locked arbiter sharing one AsyncQueueSource enqueue port among N requesters.
// Define TL_ASYNC_ARB_OUTREG_EN to add a one-entry register slice on the enqueue side.
module tl_async_source_arb #(
  parameter int N   = 4,
  parameter int W   = 64,
  parameter int IDW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  tl_async_source_arb_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_ptr_nxt;
  logic [IDW-1:0] r_owner;
  logic [IDW-1:0] w_owner_nxt;
  logic [IDW-1:0] w_grant;
  logic [IDW-1:0] w_idx;
  logic           w_found;
  logic           w_accept;
  logic           w_xfer;
  logic [W-1:0]   w_sel_bits;
  logic           w_sel_last;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
    return IDW'((int'(base) + k) % N);
  endfunction

  // Grant selection: owner while locked, else first valid searching upward from ptr.
  always_comb begin
    w_grant = {IDW{1'b0}};
    w_idx   = {IDW{1'b0}};
    w_found = 1'b0;
    case (r_state)
      ST_LOCK: begin
        w_grant = r_owner;
        w_found = bus.req_valid[r_owner];
      end
      default: begin
        for (int k = N - 1; k >= 0; k--) begin
          w_idx   = rr_idx(r_ptr, k);
          w_grant = bus.req_valid[w_idx] ? w_idx : w_grant;
        end
        w_found = |bus.req_valid;
      end
    endcase
    w_found = w_found & ~rst;
  end

  // Payload and last-flag mux of the granted requester.
  always_comb begin
    w_sel_bits = {W{1'b0}};
    w_sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_sel_bits = (w_grant == IDW'(i)) ? bus.req_bits[i*W +: W] : w_sel_bits;
      w_sel_last = (w_grant == IDW'(i)) ? bus.req_last[i]        : w_sel_last;
    end
  end

`ifdef TL_ASYNC_ARB_OUTREG_EN
  logic           r_out_valid;
  logic [W-1:0]   r_out_bits;
  logic           r_out_last;
  logic [IDW-1:0] r_out_id;

  // The slice takes a new beat whenever it is empty or draining this cycle.
  assign w_accept = ~r_out_valid | bus.out_ready;

  // Output slice registers; a non-accepting cycle holds the current beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_bits  <= {W{1'b0}};
      r_out_last  <= 1'b0;
      r_out_id    <= {IDW{1'b0}};
    end else if (w_accept) begin
      r_out_valid <= w_found;
      r_out_bits  <= w_found ? w_sel_bits : {W{1'b0}};
      r_out_last  <= w_found & w_sel_last;
      r_out_id    <= w_found ? w_grant : {IDW{1'b0}};
    end else begin
      r_out_valid <= r_out_valid;
      r_out_bits  <= r_out_bits;
      r_out_last  <= r_out_last;
      r_out_id    <= r_out_id;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_bits  = r_out_bits;
  assign bus.out_last  = r_out_last;
  assign bus.out_id    = r_out_id;
`else
  assign w_accept      = bus.out_ready;
  assign bus.out_valid = w_found;
  assign bus.out_bits  = w_found ? w_sel_bits : {W{1'b0}};
  assign bus.out_last  = w_found & w_sel_last;
  assign bus.out_id    = w_found ? w_grant : {IDW{1'b0}};
`endif

  assign w_xfer        = w_found & w_accept;
  assign bus.req_ready = w_xfer ? (N'(1) << w_grant) : {N{1'b0}};
  assign bus.busy      = (r_state == ST_LOCK);

  // Lock on a non-last beat; a last beat releases and moves priority past the winner.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    if (w_xfer && w_sel_last) begin
      w_state_nxt = ST_IDLE;
      w_ptr_nxt   = rr_idx(w_grant, 1);
    end else if (w_xfer) begin
      w_state_nxt = ST_LOCK;
      w_owner_nxt = w_grant;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= {IDW{1'b0}};
      r_owner <= {IDW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
    end
  end

endmodule
